// File: rtl/gat_feat_reader.sv
// gat_feat_reader
// Read-side engine for the GAT new-feature BRAM. After a request is accepted
// and the core reports gat_ready, it walks [rd_base, rd_base+rd_len) through
// the byte-addressed BRAM port B and streams the words out with last-beat
// marking. A credit-controlled FIFO hides the BRAM read latency, giving one
// word per cycle under continuous ready and no loss under backpressure.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   gat_ready         feature BRAM contents are valid
//   rd_start          single-cycle request pulse (rd_base / rd_len sampled)
//   rd_base, rd_len   first word index, number of words
//   feat_bram_addrb   BRAM byte address (bits [1:0] always 0)
//   feat_bram_dout    BRAM read data, RD_LATENCY cycles after the address
//   m_tdata/m_tvalid/m_tready/m_tlast  output stream
//   rd_busy           request in progress
//   rd_done           one-cycle pulse after the final beat handshakes
//   rd_err            one-cycle pulse when a request is rejected
module gat_feat_reader #(
    parameter int NEW_FEATURE_WIDTH  = 32,
    parameter int NUM_SUBGRAPHS      = 2708,
    parameter int NUM_FEATURE_OUT    = 16,
    parameter int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
    parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
    parameter int RD_LATENCY         = 2,
    parameter int FIFO_DEPTH         = RD_LATENCY + 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            gat_ready,
    input  logic                            rd_start,
    input  logic [NEW_FEATURE_ADDR_W-1:0]   rd_base,
    input  logic [NEW_FEATURE_ADDR_W:0]     rd_len,
    output logic [NEW_FEATURE_ADDR_W+1:0]   feat_bram_addrb,
    input  logic [NEW_FEATURE_WIDTH-1:0]    feat_bram_dout,
    output logic [NEW_FEATURE_WIDTH-1:0]    m_tdata,
    output logic                            m_tvalid,
    input  logic                            m_tready,
    output logic                            m_tlast,
    output logic                            rd_busy,
    output logic                            rd_done,
    output logic                            rd_err
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int IDX_W = NEW_FEATURE_ADDR_W + 1;
    localparam int SUM_W = NEW_FEATURE_ADDR_W + 2;
    localparam logic [CNT_W:0]   FIFO_FULL = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [SUM_W-1:0] DEPTH_EXT = SUM_W'(NEW_FEATURE_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_RDY, STREAM, DRAIN} state_t;
    state_t state;

    logic [IDX_W-1:0]             word_idx;
    logic [IDX_W-1:0]             end_idx;
    logic [IDX_W-1:0]             beats_sent;
    logic [IDX_W-1:0]             len_m1;
    logic [RD_LATENCY:0]          vpipe;
    logic [CNT_W-1:0]             inflight;
    logic [CNT_W-1:0]             fifo_count;
    logic [PTR_W-1:0]             wr_ptr;
    logic [PTR_W-1:0]             rd_ptr;
    logic [NEW_FEATURE_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

    logic             push;
    logic             pop;
    logic             credit;
    logic             issue;
    logic             req_bad;
    logic [CNT_W:0]   occupancy;
    logic [SUM_W-1:0] req_end;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // vpipe[0] marks an address sitting on the registered port; the BRAM needs
    // RD_LATENCY more edges, so vpipe[RD_LATENCY] is the cycle dout is valid.
    always_comb begin
        push      = vpipe[RD_LATENCY];
        pop       = m_tvalid && m_tready;
        occupancy = {1'b0, inflight} + {1'b0, fifo_count};
        // A same-cycle pop frees one slot, so a full pipe+FIFO may still issue.
        credit    = pop ? (occupancy <= FIFO_FULL) : (occupancy < FIFO_FULL);
        issue     = (state == STREAM) && credit;
        req_end   = SUM_W'(rd_base) + SUM_W'(rd_len);
        req_bad   = (rd_len == '0) || (req_end > DEPTH_EXT);
    end

    assign m_tvalid = (fifo_count != '0);
    assign m_tdata  = m_tvalid ? fifo_mem[rd_ptr] : '0;
    assign m_tlast  = m_tvalid && (beats_sent == len_m1);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= feat_bram_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            word_idx        <= '0;
            end_idx         <= '0;
            beats_sent      <= '0;
            len_m1          <= '0;
            vpipe           <= '0;
            inflight        <= '0;
            fifo_count      <= '0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            feat_bram_addrb <= '0;
            rd_busy         <= 1'b0;
            rd_done         <= 1'b0;
            rd_err          <= 1'b0;
        end else begin
            rd_done    <= 1'b0;
            rd_err     <= 1'b0;
            vpipe      <= {vpipe[RD_LATENCY-1:0], issue};
            inflight   <= inflight + CNT_W'(issue) - CNT_W'(push);
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr     <= ptr_next(rd_ptr);
                beats_sent <= beats_sent + IDX_W'(1);
            end
            if (issue) begin
                feat_bram_addrb <= {word_idx[NEW_FEATURE_ADDR_W-1:0], 2'b00};
                word_idx        <= word_idx + IDX_W'(1);
            end

            case (state)
                IDLE: begin
                    if (rd_start) begin
                        if (req_bad) begin
                            rd_err <= 1'b1;
                        end else begin
                            word_idx   <= IDX_W'(rd_base);
                            end_idx    <= req_end[IDX_W-1:0];
                            len_m1     <= rd_len - IDX_W'(1);
                            beats_sent <= '0;
                            rd_busy    <= 1'b1;
                            state      <= WAIT_RDY;
                        end
                    end
                end
                WAIT_RDY: begin
                    if (rd_start) rd_err <= 1'b1;
                    if (gat_ready) state <= STREAM;
                end
                STREAM: begin
                    if (rd_start) rd_err <= 1'b1;
                    if (issue && (word_idx + IDX_W'(1) == end_idx)) state <= DRAIN;
                end
                DRAIN: begin
                    if (rd_start) rd_err <= 1'b1;
                    // The tlast beat is the last entry, so its pop leaves the
                    // FIFO empty with nothing in flight.
                    if (pop && m_tlast) begin
                        rd_done <= 1'b1;
                        rd_busy <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push && !pop) begin
            assert (fifo_count < CNT_W'(FIFO_DEPTH))
                else $error("feature FIFO overflow");
        end
    end
endmodule

// File: tb/tb_gat_feat_reader.sv
`timescale 1ns/1ps
module tb_gat_feat_reader;
    localparam int W     = 32;
    localparam int DEPTH = 43328;
    localparam int AW    = 16;
    localparam int LAT   = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          gat_ready;
    logic          rd_start;
    logic [AW-1:0] rd_base;
    logic [AW:0]   rd_len;
    logic [AW+1:0] feat_bram_addrb;
    logic [W-1:0]  feat_bram_dout;
    logic [W-1:0]  m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic          rd_busy;
    logic          rd_done;
    logic          rd_err;

    int n_checks = 0;
    int n_fail   = 0;

    gat_feat_reader #(
        .NEW_FEATURE_WIDTH(W),
        .NUM_SUBGRAPHS(2708),
        .NUM_FEATURE_OUT(16),
        .RD_LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst), .gat_ready(gat_ready), .rd_start(rd_start),
        .rd_base(rd_base), .rd_len(rd_len), .feat_bram_addrb(feat_bram_addrb),
        .feat_bram_dout(feat_bram_dout), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
        .m_tready(m_tready), .m_tlast(m_tlast), .rd_busy(rd_busy),
        .rd_done(rd_done), .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    // BRAM model: word k holds k, two registered read stages after the address.
    logic [W-1:0] bram_q0, bram_q1;
    always @(posedge clk) begin
        bram_q0 <= W'(feat_bram_addrb[AW+1:2]);
        bram_q1 <= bram_q0;
    end
    assign feat_bram_dout = bram_q1;

    // Beats captured by collect(); cycle numbers count edges after rd_start.
    logic [W-1:0] b_data[$];
    bit           b_last[$];
    int           b_cyc[$];
    int first_valid_c, first_addr_c, done_c, err_c, max_occ, stall_viol;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no summary expected summary");
        $fatal(1, "time limit");
    end

    // Called at an observation point; leaves the bench at observation c=0.
    task automatic start_req(input int base, input int len, input logic gr);
        rd_base   = AW'(base);
        rd_len    = (AW + 1)'(len);
        rd_start  = 1'b1;
        gat_ready = gr;
        @(posedge clk); #1;
        rd_start  = 1'b0;
    endtask

    // mode 0: ready always high; mode 1: ready on even cycles, low for c=12..21.
    task automatic collect(input int max_cyc, input int mode, input int gr_cyc,
                           input int gr_fall, input int inj_cyc, output bit timed_out);
        logic [AW+1:0] addr0;
        logic [W-1:0]  prev_data;
        logic          prev_last;
        bit            prev_stall;
        int            occ;
        b_data.delete(); b_last.delete(); b_cyc.delete();
        first_valid_c = -1; first_addr_c = -1; done_c = -1; err_c = -1;
        max_occ = 0; stall_viol = 0;
        addr0 = feat_bram_addrb;
        prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
        timed_out = 1'b1;
        for (int c = 0; c <= max_cyc; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            if (first_valid_c < 0 && m_tvalid === 1'b1) first_valid_c = c;
            if (first_addr_c < 0 && feat_bram_addrb !== addr0) first_addr_c = c;
            if (err_c < 0 && rd_err === 1'b1) err_c = c;
            occ = int'(dut.inflight) + int'(dut.fifo_count);
            if (occ > max_occ) max_occ = occ;
            if (prev_stall && (m_tvalid !== 1'b1 || m_tdata !== prev_data || m_tlast !== prev_last))
                stall_viol++;
            if (rd_done === 1'b1) begin
                done_c = c;
                timed_out = 1'b0;
                break;
            end
            gat_ready = (c >= gr_cyc) && (c < gr_fall);
            rd_start  = (c == inj_cyc);
            if (mode == 1) m_tready = (c >= 12 && c < 22) ? 1'b0 : (c % 2 == 0);
            else           m_tready = 1'b1;
            if (m_tvalid === 1'b1 && m_tready) begin
                b_data.push_back(m_tdata);
                b_last.push_back(m_tlast);
                b_cyc.push_back(c);
            end
            prev_stall = (m_tvalid === 1'b1) && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
        end
        rd_start = 1'b0;
        m_tready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; gat_ready = 1'b0; rd_start = 1'b0; m_tready = 1'b0;
        rd_base = '0; rd_len = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b expected 0", m_tvalid); end
        n_checks++; if (m_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %b expected 0", m_tlast); end
        n_checks++; if (m_tdata !== 32'd0) begin n_fail++; $display("FAIL reset_tdata: got %0h expected 0", m_tdata); end
        n_checks++; if (rd_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", rd_busy); end
        n_checks++; if (rd_done !== 1'b0 || rd_err !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got done=%b err=%b expected 0 0", rd_done, rd_err); end
        n_checks++; if (feat_bram_addrb !== '0) begin n_fail++; $display("FAIL reset_addrb: got %0h expected 0", feat_bram_addrb); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (rd_busy !== 1'b0 || m_tvalid !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got busy=%b valid=%b expected 0 0", rd_busy, m_tvalid); end
    endtask

    task automatic test_full_subgraph();
        bit to;
        int bad;
        start_req(0, 16, 1'b1);
        n_checks++; if (rd_busy !== 1'b1) begin n_fail++; $display("FAIL full_busy: got %b expected 1", rd_busy); end
        collect(60, 0, 0, 1000, -1, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL full_timeout: got no rd_done expected rd_done"); end
        n_checks++; if (first_valid_c !== 5) begin n_fail++; $display("FAIL full_first_valid: got %0d expected 5", first_valid_c); end
        n_checks++; if (b_data.size() !== 16) begin n_fail++; $display("FAIL full_beats: got %0d expected 16", b_data.size()); end
        bad = 0;
        for (int i = 0; i < b_data.size(); i++)
            if (b_data[i] !== 32'(i) || b_last[i] !== (i == 15) || b_cyc[i] !== 5 + i) bad++;
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL full_data_last_timing: got %0d bad beats expected 0", bad); end
        n_checks++; if (done_c !== 21) begin n_fail++; $display("FAIL full_done_cycle: got %0d expected 21", done_c); end
        n_checks++; if (rd_busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_drop: got %b expected 0", rd_busy); end
    endtask

    task automatic test_backpressure();
        bit to;
        int bad;
        start_req(0, 32, 1'b1);
        collect(300, 1, 0, 1000, -1, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL bp_timeout: got no rd_done expected rd_done"); end
        n_checks++; if (b_data.size() !== 32) begin n_fail++; $display("FAIL bp_beats: got %0d expected 32", b_data.size()); end
        bad = 0;
        for (int i = 0; i < b_data.size(); i++)
            if (b_data[i] !== 32'(i) || b_last[i] !== (i == 31)) bad++;
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL bp_order: got %0d bad beats expected 0", bad); end
        n_checks++; if (max_occ > 4) begin n_fail++; $display("FAIL bp_occupancy: got %0d expected at most 4", max_occ); end
        n_checks++; if (stall_viol !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes during stall expected 0", stall_viol); end
        if (b_cyc.size() > 0) begin
            n_checks++; if (done_c !== b_cyc[b_cyc.size()-1] + 1) begin n_fail++; $display("FAIL bp_done_cycle: got %0d expected %0d", done_c, b_cyc[b_cyc.size()-1] + 1); end
        end
    endtask

    task automatic test_boundary();
        bit to;
        int bad;
        start_req(43312, 16, 1'b1);
        collect(60, 0, 0, 1000, -1, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL bnd_timeout: got no rd_done expected rd_done"); end
        n_checks++; if (first_addr_c !== 2) begin n_fail++; $display("FAIL bnd_first_addr: got %0d expected 2", first_addr_c); end
        n_checks++; if (b_data.size() !== 16) begin n_fail++; $display("FAIL bnd_beats: got %0d expected 16", b_data.size()); end
        bad = 0;
        for (int i = 0; i < b_data.size(); i++)
            if (b_data[i] !== 32'(43312 + i) || b_last[i] !== (i == 15)) bad++;
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL bnd_data: got %0d bad beats expected 0", bad); end
        n_checks++; if (feat_bram_addrb !== 18'(43327 * 4)) begin n_fail++; $display("FAIL bnd_last_addr: got %0d expected %0d", feat_bram_addrb, 43327 * 4); end
    endtask

    task automatic test_errors();
        int seen_valid;
        start_req(43320, 16, 1'b1);
        n_checks++; if (rd_err !== 1'b1) begin n_fail++; $display("FAIL err_range_pulse: got %b expected 1", rd_err); end
        n_checks++; if (rd_busy !== 1'b0) begin n_fail++; $display("FAIL err_range_busy: got %b expected 0", rd_busy); end
        @(posedge clk); #1;
        n_checks++; if (rd_err !== 1'b0) begin n_fail++; $display("FAIL err_pulse_width: got %b expected 0", rd_err); end
        seen_valid = 0;
        for (int i = 0; i < 8; i++) begin
            if (m_tvalid !== 1'b0) seen_valid++;
            @(posedge clk); #1;
        end
        n_checks++; if (seen_valid !== 0) begin n_fail++; $display("FAIL err_range_no_valid: got %0d valid cycles expected 0", seen_valid); end
        n_checks++; if (feat_bram_addrb !== 18'(43327 * 4)) begin n_fail++; $display("FAIL err_addr_hold: got %0d expected %0d", feat_bram_addrb, 43327 * 4); end
        start_req(5, 0, 1'b1);
        n_checks++; if (rd_err !== 1'b1 || rd_busy !== 1'b0) begin n_fail++; $display("FAIL err_len0: got err=%b busy=%b expected 1 0", rd_err, rd_busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_full_depth();
        bit to;
        int bad, nlast;
        start_req(0, DEPTH, 1'b1);
        collect(DEPTH + 100, 0, 0, DEPTH + 1000, -1, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL depth_timeout: got no rd_done expected rd_done"); end
        n_checks++; if (b_data.size() !== DEPTH) begin n_fail++; $display("FAIL depth_beats: got %0d expected %0d", b_data.size(), DEPTH); end
        bad = 0; nlast = 0;
        for (int i = 0; i < b_data.size(); i++) begin
            if (b_data[i] !== 32'(i)) bad++;
            if (b_last[i]) nlast++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL depth_data: got %0d bad beats expected 0", bad); end
        n_checks++; if (nlast !== 1) begin n_fail++; $display("FAIL depth_tlast_count: got %0d expected 1", nlast); end
        if (b_data.size() == DEPTH) begin
            n_checks++; if (b_last[DEPTH-1] !== 1'b1) begin n_fail++; $display("FAIL depth_tlast_pos: got %b expected 1", b_last[DEPTH-1]); end
            n_checks++; if (b_cyc[DEPTH-1] !== 5 + DEPTH - 1) begin n_fail++; $display("FAIL depth_throughput: got %0d expected %0d", b_cyc[DEPTH-1], 5 + DEPTH - 1); end
        end
    endtask

    task automatic test_gating();
        bit to;
        int bad;
        start_req(200, 8, 1'b0);
        collect(80, 0, 20, 1000, -1, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL gate_timeout: got no rd_done expected rd_done"); end
        n_checks++; if (first_addr_c !== 22) begin n_fail++; $display("FAIL gate_first_addr: got %0d expected 22", first_addr_c); end
        n_checks++; if (first_valid_c !== 25) begin n_fail++; $display("FAIL gate_first_valid: got %0d expected 25", first_valid_c); end
        bad = (b_data.size() == 8) ? 0 : 1;
        for (int i = 0; i < b_data.size(); i++)
            if (b_data[i] !== 32'(200 + i) || b_last[i] !== (i == 7)) bad++;
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL gate_data: got %0d errors expected 0", bad); end
    endtask

    task automatic test_overlap();
        bit to;
        int bad;
        start_req(0, 16, 1'b1);
        collect(60, 0, 0, 9, 8, to);
        n_checks++; if (err_c !== 9) begin n_fail++; $display("FAIL ovl_err_cycle: got %0d expected 9", err_c); end
        n_checks++; if (to) begin n_fail++; $display("FAIL ovl_timeout: got no rd_done expected rd_done"); end
        bad = (b_data.size() == 16) ? 0 : 1;
        for (int i = 0; i < b_data.size(); i++)
            if (b_data[i] !== 32'(i) || b_last[i] !== (i == 15) || b_cyc[i] !== 5 + i) bad++;
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL ovl_stream: got %0d errors expected 0", bad); end
        n_checks++; if (done_c !== 21) begin n_fail++; $display("FAIL ovl_done_cycle: got %0d expected 21", done_c); end
    endtask

    task automatic test_reset_mid();
        bit to, hit;
        int beats, bad, stray;
        start_req(0, 16, 1'b1);
        beats = 0; hit = 1'b0;
        for (int c = 0; c < 60; c++) begin
            m_tready = 1'b1;
            if (m_tvalid === 1'b1) beats++;
            if (beats == 6) begin
                hit = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        n_checks++; if (!hit) begin n_fail++; $display("FAIL rstmid_reach_beat5: got %0d beats expected 6", beats); end
        @(posedge clk); #1;
        rst = 1'b1; m_tready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++; if (m_tvalid !== 1'b0 || rd_busy !== 1'b0 || rd_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_state: got valid=%b busy=%b done=%b expected 0 0 0", m_tvalid, rd_busy, rd_done); end
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (rd_done !== 1'b0 || m_tvalid !== 1'b0 || rd_busy !== 1'b0) stray++;
        end
        n_checks++; if (stray !== 0) begin n_fail++; $display("FAIL rstmid_quiet: got %0d active cycles expected 0", stray); end
        start_req(0, 4, 1'b1);
        collect(40, 0, 0, 1000, -1, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL rstmid_timeout: got no rd_done expected rd_done"); end
        bad = (b_data.size() == 4) ? 0 : 1;
        for (int i = 0; i < b_data.size(); i++)
            if (b_data[i] !== 32'(i) || b_last[i] !== (i == 3)) bad++;
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rstmid_restart: got %0d errors expected 0", bad); end
        n_checks++; if (first_valid_c !== 5) begin n_fail++; $display("FAIL rstmid_first_valid: got %0d expected 5", first_valid_c); end
    endtask

    initial begin
        test_reset();
        test_full_subgraph();
        test_backpressure();
        test_boundary();
        test_errors();
        test_full_depth();
        test_gating();
        test_overlap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
